// File: rtl/dram_phy_pkg.sv
// Shared types and constants for the DDR3 PHY read-capture trainer.
//  TAP_W / NUM_TAPS : IDELAYE2 tap field width and tap count
//  MPR_PATTERN      : {Q4,Q3,Q2,Q1} expected on every DQ bit of a passing MPR read
//  train_state_t    : trainer FSM states
//  win_centre()     : centre tap of a window, 6-bit unsigned math truncated to a tap
package dram_phy_pkg;

  localparam int         TAP_W       = 5;
  localparam int         NUM_TAPS    = 32;
  localparam logic [3:0] MPR_PATTERN = 4'b1010;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_REQ,
    ST_WAIT,
    ST_EVAL,
    ST_CENTER,
    ST_APPLY,
    ST_NEXT,
    ST_DONE,
    ST_ABORT
  } train_state_t;

  function automatic logic [TAP_W-1:0] win_centre(input logic [5:0] start,
                                                  input logic [5:0] len);
    logic [5:0] c;
    c = start + ((len - 6'd1) >> 1);
    return c[TAP_W-1:0];
  endfunction

endpackage

// File: rtl/dram_win_track.sv
// Widest-contiguous-pass window tracker for one tap sweep.
//  clk, rst   : clock, async active-high reset
//  clr        : clear all run/best state (new lane)
//  en         : one tap result is presented this cycle
//  pass       : that tap passed
//  tap_in     : tap index of the result
//  last       : this is the final tap; an open run is closed now
//  best_start : first tap of the widest run seen (earliest on ties)
//  best_len   : length of that run (0..32)
module dram_win_track import dram_phy_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             pass,
  input  logic [TAP_W-1:0] tap_in,
  input  logic             last,
  output logic [5:0]       best_start,
  output logic [5:0]       best_len
);

  logic [5:0] cur_start_q, cur_start_d, cur_len_q, cur_len_d;
  logic [5:0] best_start_q, best_start_d, best_len_q, best_len_d;
  logic [5:0] run_len, run_start;

  always_comb begin
    // Run as it stands including this tap; on a fail it is the run being closed.
    run_len      = pass ? cur_len_q + 6'd1 : cur_len_q;
    run_start    = (cur_len_q == 6'd0) ? {1'b0, tap_in} : cur_start_q;
    cur_start_d  = cur_start_q;
    cur_len_d    = cur_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    if (clr) begin
      cur_start_d  = '0;
      cur_len_d    = '0;
      best_start_d = '0;
      best_len_d   = '0;
    end else if (en) begin
      if (!pass || last) begin
        // Strict compare: an equal later window never displaces the earlier one.
        if (run_len > best_len_q) begin
          best_len_d   = run_len;
          best_start_d = run_start;
        end
        cur_len_d = '0;
      end else begin
        cur_len_d   = run_len;
        cur_start_d = run_start;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_start_q  <= '0;
      cur_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
    end else begin
      cur_start_q  <= cur_start_d;
      cur_len_q    <= cur_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
    end
  end

  assign best_start = best_start_q;
  assign best_len   = best_len_q;

endmodule

// File: rtl/dram_rd_dly_train.sv
// Read-capture IDELAY trainer. One lane at a time: sweep taps 0..31, read the MPR
// pattern SAMPLES times per tap, track the widest passing window, load its centre.
//  clk, rst        : fabric clock, async active-high reset
//  idelayctl_rdy   : IDELAYCTRL ready, gates leaving IDLE
//  start / busy / done : control handshake (done is a 1-cycle pulse)
//  timeout_err     : sticky, set on read timeout abort
//  lane_fail       : sticky per lane, window narrower than MIN_WIN
//  rd_req / rd_ack / rd_valid / rd_data : MPR read interface
//  dly_cntvalue / dly_ld : per-lane IDELAY CNTVALUEIN and LD
module dram_rd_dly_train import dram_phy_pkg::*; #(
  parameter int W       = 8,
  parameter int SAMPLES = 4,
  parameter int SETTLE  = 8,
  parameter int MIN_WIN = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               idelayctl_rdy,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               timeout_err,
  output logic [W-1:0]       lane_fail,
  output logic               rd_req,
  input  logic               rd_ack,
  input  logic               rd_valid,
  input  logic [W*32-1:0]    rd_data,
  output logic [W*TAP_W-1:0] dly_cntvalue,
  output logic [W-1:0]       dly_ld
);

  localparam int LW  = (W > 1) ? $clog2(W) : 1;
  localparam int SMW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
  localparam int CW  = $clog2(SETTLE + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);

  train_state_t               state_q, state_d;
  logic [LW-1:0]              lane_q, lane_d;
  logic [TAP_W-1:0]           tap_q, tap_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [SMW-1:0]             samp_q, samp_d;
  logic [TW-1:0]              tmr_q, tmr_d;
  logic                       tap_pass_q, tap_pass_d;
  logic [W-1:0][TAP_W-1:0]    cv_q, cv_d;
  logic [W-1:0]               fail_q, fail_d;
  logic                       terr_q, terr_d;

  logic                       trk_clr, trk_en;
  logic [5:0]                 best_start, best_len;
  logic [31:0]                lane_data;
  logic                       rd_pass;
  logic                       win_ok;

  dram_win_track u_trk (
    .clk        (clk),
    .rst        (rst),
    .clr        (trk_clr),
    .en         (trk_en),
    .pass       (tap_pass_q),
    .tap_in     (tap_q),
    .last       (tap_q == TAP_W'(NUM_TAPS - 1)),
    .best_start (best_start),
    .best_len   (best_len)
  );

  // A read passes only if all 8 DQ nibbles of the active lane match.
  always_comb begin
    lane_data = rd_data[{lane_q, 5'd0} +: 32];
    rd_pass   = 1'b1;
    for (int i = 0; i < 8; i++)
      if (lane_data[i*4 +: 4] != MPR_PATTERN) rd_pass = 1'b0;
  end

  assign win_ok = (best_len >= 6'(MIN_WIN));

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    tap_d      = tap_q;
    cnt_d      = cnt_q;
    samp_d     = samp_q;
    tmr_d      = tmr_q;
    tap_pass_d = tap_pass_q;
    cv_d       = cv_q;
    fail_d     = fail_q;
    terr_d     = terr_q;
    trk_clr    = 1'b0;
    trk_en     = 1'b0;
    rd_req     = 1'b0;
    dly_ld     = '0;
    done       = 1'b0;
    // cntvalue is written on the way into LOAD/APPLY so it is already stable
    // on the cycle LD is high.
    unique case (state_q)
      ST_IDLE: if (start && idelayctl_rdy) begin
        lane_d  = '0;
        tap_d   = '0;
        cv_d[0] = '0;
        fail_d  = '0;
        terr_d  = 1'b0;
        trk_clr = 1'b1;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        dly_ld[lane_q] = 1'b1;
        tap_pass_d     = 1'b1;
        samp_d         = '0;
        cnt_d          = '0;
        state_d        = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == CW'(SETTLE - 1)) begin
          cnt_d   = '0;
          state_d = ST_REQ;
        end else cnt_d = cnt_q + 1'b1;
      end
      ST_REQ: begin
        rd_req = 1'b1;
        if (rd_ack) begin
          tmr_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (rd_valid) begin
          tap_pass_d = tap_pass_q & rd_pass;
          if (samp_q == SMW'(SAMPLES - 1)) state_d = ST_EVAL;
          else begin
            samp_d  = samp_q + 1'b1;
            state_d = ST_REQ;
          end
        end else if (tmr_q == TW'(TIMEOUT)) state_d = ST_ABORT;
        else tmr_d = tmr_q + 1'b1;
      end
      ST_EVAL: begin
        trk_en = 1'b1;
        if (tap_q == TAP_W'(NUM_TAPS - 1)) state_d = ST_CENTER;
        else begin
          tap_d        = tap_q + 1'b1;
          cv_d[lane_q] = tap_q + 1'b1;
          state_d      = ST_LOAD;
        end
      end
      ST_CENTER: begin
        cv_d[lane_q] = win_ok ? win_centre(best_start, best_len) : '0;
        if (!win_ok) fail_d[lane_q] = 1'b1;
        cnt_d   = '0;
        state_d = ST_APPLY;
      end
      ST_APPLY: begin
        if (cnt_q == '0) dly_ld[lane_q] = 1'b1;
        if (cnt_q == CW'(SETTLE)) state_d = ST_NEXT;
        else cnt_d = cnt_q + 1'b1;
      end
      ST_NEXT: begin
        if (lane_q == LW'(W - 1)) state_d = ST_DONE;
        else begin
          lane_d       = lane_q + 1'b1;
          tap_d        = '0;
          cv_d[lane_d] = '0;
          trk_clr      = 1'b1;
          state_d      = ST_LOAD;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ABORT: begin
        done    = 1'b1;
        terr_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      lane_q     <= '0;
      tap_q      <= '0;
      cnt_q      <= '0;
      samp_q     <= '0;
      tmr_q      <= '0;
      tap_pass_q <= 1'b1;
      cv_q       <= '0;
      fail_q     <= '0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      tap_q      <= tap_d;
      cnt_q      <= cnt_d;
      samp_q     <= samp_d;
      tmr_q      <= tmr_d;
      tap_pass_q <= tap_pass_d;
      cv_q       <= cv_d;
      fail_q     <= fail_d;
      terr_q     <= terr_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign timeout_err  = terr_q;
  assign lane_fail    = fail_q;
  assign dly_cntvalue = cv_q;

endmodule

// File: tb/tb_dram_rd_dly_train.sv
// Bench for dram_rd_dly_train: an IDELAY + MPR read responder driven by per-lane
// pass maps, and a window model computing expected centre taps from those maps.
module tb_dram_rd_dly_train;
  localparam int W = 8;

  logic            clk = 1'b0;
  logic            rst, idelayctl_rdy, start, rd_ack, rd_valid;
  logic            busy, done, timeout_err, rd_req;
  logic [W-1:0]    lane_fail, dly_ld;
  logic [W*32-1:0] rd_data;
  logic [W*5-1:0]  dly_cntvalue;

  int errs = 0, checks = 0;

  always #5 clk = ~clk;

  dram_rd_dly_train #(.W(W)) dut (
    .clk(clk), .rst(rst), .idelayctl_rdy(idelayctl_rdy), .start(start),
    .busy(busy), .done(done), .timeout_err(timeout_err), .lane_fail(lane_fail),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .dly_cntvalue(dly_cntvalue), .dly_ld(dly_ld)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- PHY side model ----------------
  logic [4:0]  tap_m [W];
  int          act_lane = 0;
  logic [31:0] pmap [W];
  int          inj_lane = -1;
  int          inj_cnt = 0;
  bit          hold_lane1 = 0;
  int          done_cnt = 0, ld_multi = 0;

  always @(posedge clk)
    for (int b = 0; b < W; b++)
      if (dly_ld[b]) begin
        tap_m[b] <= dly_cntvalue[b*5 +: 5];
        act_lane <= b;
      end

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if ($countones(dly_ld) > 1) ld_multi <= ld_multi + 1;
  end

  task automatic build_data();
    logic [31:0] d;
    for (int b = 0; b < W; b++) begin
      d = pmap[b][tap_m[b]] ? 32'hAAAA_AAAA
                            : (32'hAAAA_AAAA ^ (32'h1 << $urandom_range(0, 31)));
      if (b == inj_lane && b == act_lane && tap_m[b] == 5'd12) begin
        inj_cnt++;
        if (inj_cnt % 3 == 0) d = 32'hAAAA_AAAA ^ 32'h0000_0100;
      end
      rd_data[b*32 +: 32] = d;
    end
  endtask

  initial begin
    rd_ack = 0; rd_valid = 0; rd_data = '0;
    forever begin
      @(posedge clk); #1;
      if (rd_req) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        rd_ack = 1; @(posedge clk); #1; rd_ack = 0;
        if (!(hold_lane1 && act_lane == 1)) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          build_data();
          rd_valid = 1; @(posedge clk); #1; rd_valid = 0;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic [4:0]   exp_cv [W];
  logic [W-1:0] exp_fail;

  function automatic logic [31:0] win(input int s, input int e);
    logic [31:0] m = '0;
    for (int t = s; t <= e && t < 32; t++) m[t] = 1'b1;
    return m;
  endfunction

  // Scan all maximal runs; the first run of the greatest length wins.
  task automatic model_lane(input int b, input logic [31:0] m);
    int bs = 0, bl = 0, s, l, t;
    t = 0;
    while (t < 32) begin
      if (m[t]) begin
        s = t; l = 0;
        while (t < 32 && m[t]) begin l++; t++; end
        if (l > bl) begin bl = l; bs = s; end
      end else t++;
    end
    exp_fail[b] = (bl < 4);
    exp_cv[b]   = (bl < 4) ? 5'd0 : 5'(bs + (bl - 1) / 2);
  endtask

  task automatic run_train(input string tag, input bit exp_terr);
    int n, d0;
    d0 = done_cnt;
    @(posedge clk); #1 start = 1; @(posedge clk); #1 start = 0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    n = 0;
    while (done_cnt == d0 && n < 60000) begin @(negedge clk); n++; end
    chk({tag, "_done_seen"}, 64'(done_cnt != d0), 64'd1);
    repeat (3) @(negedge clk);
    chk({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    chk({tag, "_terr"}, 64'(timeout_err), 64'(exp_terr));
    chk({tag, "_lane_fail"}, 64'(lane_fail), 64'(exp_fail));
    for (int b = 0; b < W; b++)
      chk($sformatf("%s_cv%0d", tag, b), 64'(dly_cntvalue[b*5 +: 5]), 64'(exp_cv[b]));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] m;
    int n, d0, s;
    rst = 1; idelayctl_rdy = 1; start = 0;
    for (int b = 0; b < W; b++) begin exp_cv[b] = 0; pmap[b] = '1; end
    exp_fail = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_req", 64'(rd_req), 0);
    chk("rst_ld", 64'(dly_ld), 0);
    chk("rst_cv", 64'(dly_cntvalue), 0);
    chk("rst_fail", 64'(lane_fail), 0);
    chk("rst_terr", 64'(timeout_err), 0);
    @(posedge clk); #1 rst = 0;

    // A: lane 0 on 10..19, others 3..28
    for (int b = 0; b < W; b++) pmap[b] = (b == 0) ? win(10, 19) : win(3, 28);
    for (int b = 0; b < W; b++) model_lane(b, pmap[b]);
    run_train("A", 0);

    // B: two windows, equal windows, narrow lane, tap-12 intermittent split
    for (int b = 0; b < W; b++) pmap[b] = win(3, 28);
    pmap[2] = win(2, 5) | win(20, 27);
    pmap[4] = win(5, 25);
    pmap[5] = win(7, 9);
    pmap[6] = win(2, 5) | win(9, 12);
    inj_lane = 4;
    for (int b = 0; b < W; b++) begin
      m = pmap[b];
      if (b == 4) m[12] = 1'b0;
      model_lane(b, m);
    end
    run_train("B", 0);
    inj_lane = -1;

    // D: read timeout during lane 1; lanes 2..7 keep their B values
    for (int b = 0; b < W; b++) pmap[b] = '1;
    hold_lane1 = 1;
    exp_cv[0] = 5'd15; exp_cv[1] = 5'd0; exp_fail = '0;
    run_train("D", 1);
    hold_lane1 = 0;

    // C: random maps
    for (int b = 0; b < W; b++) begin
      s = $urandom_range(0, 31);
      m = win(s, s + $urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        s = $urandom_range(0, 31);
        m = m | win(s, s + $urandom_range(0, 12));
      end
      if ($urandom_range(0, 2) == 0) m[$urandom_range(0, 31)] = ~m[$urandom_range(0, 31)];
      pmap[b] = m;
      model_lane(b, m);
    end
    run_train("C", 0);

    // E: reset mid-sweep on lane 3, then start with IDELAYCTRL not ready
    for (int b = 0; b < W; b++) pmap[b] = '1;
    d0 = done_cnt;
    @(posedge clk); #1 start = 1; @(posedge clk); #1 start = 0;
    n = 0;
    while (act_lane != 3 && n < 40000) begin @(negedge clk); n++; end
    chk("E_reach_lane3", 64'(act_lane), 64'd3);
    repeat (20) @(negedge clk);
    chk("E_busy_mid", 64'(busy), 64'd1);
    rst = 1;
    repeat (3) @(negedge clk);
    chk("E_rst_busy", 64'(busy), 0);
    chk("E_rst_req", 64'(rd_req), 0);
    chk("E_rst_ld", 64'(dly_ld), 0);
    chk("E_rst_cv", 64'(dly_cntvalue), 0);
    chk("E_rst_fail", 64'(lane_fail), 0);
    chk("E_rst_terr", 64'(timeout_err), 0);
    @(posedge clk); #1 rst = 0; idelayctl_rdy = 0;
    repeat (10) @(negedge clk);
    @(posedge clk); #1 start = 1; @(posedge clk); #1 start = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || rd_req) break;
    end
    chk("E_nordy_busy", 64'(busy), 0);
    chk("E_nordy_req", 64'(rd_req), 0);
    chk("E_no_done", 64'(done_cnt - d0), 0);

    chk("ld_one_hot", 64'(ld_multi), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
